if_fetch_ctrl: RTL and testbench

- Sequences instruction fetch from a multi-cycle, handshaked instruction memory and presents one instruction at a time to the decode stage.
- Replaces the free-running PC/ROM pairing when the instruction memory gains request/grant/response latency.
- Owns the fetch PC, holds at most one outstanding request, and applies stall and branch redirects.
- Discards responses that return after a redirect.

---
 rtl/if_fetch_ctrl.sv | 152 +++++++++++++++
 tb/tb_if_fetch_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_ctrl.sv
// Instruction fetch sequencer for a handshaked, multi-cycle instruction memory.
// Keeps one request in flight at most. A one-entry skid buffer catches a
// response that lands while decode is stalled. A kill flag discards a response
// whose request was overtaken by a branch redirect.
`timescale 1ns/1ps

module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch,
    input  logic [31:0] jump_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC_IF,
    output logic [31:0] inst_IF,
    output logic        inst_valid
);

    // REQ: request on the bus. WAIT: granted, awaiting data.
    // HOLD: data parked in the skid buffer. The skid is occupied exactly
    // when the FSM is in HOLD, so no separate occupancy flag is kept.
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [31:0] START_PC = RESET_PC & ~32'h3;

    state_t      state, state_n;
    logic [31:0] fetch_pc, fetch_pc_n;
    logic        kill, kill_n;
    logic [31:0] skid_pc, skid_inst;
    logic        skid_load;
    logic [31:0] pc_if_n, inst_if_n;
    logic        inst_valid_n;
    logic        consume, loadable;

    // Control state and the presented instruction; cleared by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_REQ;
            fetch_pc   <= START_PC;
            kill       <= 1'b0;
            PC_IF      <= START_PC;
            inst_IF    <= 32'h0;
            inst_valid <= 1'b0;
        end else begin
            state      <= state_n;
            fetch_pc   <= fetch_pc_n;
            kill       <= kill_n;
            PC_IF      <= pc_if_n;
            inst_IF    <= inst_if_n;
            inst_valid <= inst_valid_n;
        end
    end

    // Skid payload; only meaningful while in HOLD, so it needs no reset.
    always_ff @(posedge clk) begin
        if (skid_load) begin
            skid_pc   <= fetch_pc;
            skid_inst <= imem_rdata;
        end
    end

    // Next-state and bus outputs; the request depends on registered state only.
    always_comb begin
        state_n      = state;
        fetch_pc_n   = fetch_pc;
        kill_n       = kill;
        pc_if_n      = PC_IF;
        inst_if_n    = inst_IF;
        inst_valid_n = inst_valid;
        skid_load    = 1'b0;
        imem_req     = rst && (state == S_REQ);
        imem_addr    = fetch_pc;
        consume      = inst_valid && !stall;
        loadable     = !inst_valid || !stall;

        if (branch) begin
            // Redirect overrides everything: flush output and skid, refetch.
            inst_valid_n = 1'b0;
            fetch_pc_n   = jump_addr & ~32'h3;
            case (state)
                S_REQ: begin
                    if (imem_gnt) begin
                        state_n = S_WAIT;
                        kill_n  = 1'b1;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        state_n = S_REQ;
                        kill_n  = 1'b0;
                    end else begin
                        kill_n  = 1'b1;
                    end
                end
                default: begin
                    state_n = S_REQ;
                    kill_n  = 1'b0;
                end
            endcase
        end else begin
            case (state)
                S_REQ: begin
                    if (consume) inst_valid_n = 1'b0;
                    if (imem_gnt) state_n = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (kill) begin
                            // Stale response from before a redirect.
                            kill_n  = 1'b0;
                            state_n = S_REQ;
                            if (consume) inst_valid_n = 1'b0;
                        end else if (loadable) begin
                            pc_if_n      = fetch_pc;
                            inst_if_n    = imem_rdata;
                            inst_valid_n = 1'b1;
                            fetch_pc_n   = fetch_pc + 32'd4;
                            state_n      = S_REQ;
                        end else begin
                            skid_load  = 1'b1;
                            fetch_pc_n = fetch_pc + 32'd4;
                            state_n    = S_HOLD;
                        end
                    end else if (consume) begin
                        inst_valid_n = 1'b0;
                    end
                end
                S_HOLD: begin
                    if (consume) begin
                        pc_if_n   = skid_pc;
                        inst_if_n = skid_inst;
                        state_n   = S_REQ;
                    end
                end
                default: begin
                    state_n = S_REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: a transaction-level model (queues of in-flight and
// parked fetches) is compared with the DUT every cycle, with directed scenarios
// carrying hand-computed expectations, followed by a randomized run.
`timescale 1ns/1ps

module tb_if_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] SALT     = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        branch = 1'b0;
    logic [31:0] jump_addr = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] PC_IF;
    logic [31:0] inst_IF;
    logic        inst_valid;

    if_fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .stall(stall), .branch(branch), .jump_addr(jump_addr),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .PC_IF(PC_IF), .inst_IF(inst_IF), .inst_valid(inst_valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- memory responder ----------------
    bit          mem_pend = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = 32'h0;

    task automatic drive_cycle(input bit st, input bit br, input logic [31:0] ja,
                               input int gnt_pct, input int dmin, input int dmax);
        @(negedge clk);
        stall       = st;
        branch      = br;
        jump_addr   = ja;
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        imem_gnt    = 1'b0;
        if (mem_pend) begin
            if (mem_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_addr ^ SALT;
                mem_pend    = 1'b0;
            end else begin
                mem_cnt--;
            end
        end
        if (!mem_pend && imem_req && (int'($urandom_range(99, 0)) < gnt_pct)) begin
            imem_gnt = 1'b1;
            mem_pend = 1'b1;
            mem_addr = imem_addr;
            mem_cnt  = int'($urandom_range(dmax, dmin)) - 1;
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { logic [31:0] pc; bit dead; } fl_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;

    fl_t         infl[$];
    ent_t        held[$];
    logic [31:0] m_pc, m_pcif, m_inst;
    bit          m_valid;

    function automatic bit m_req();
        return (rst === 1'b1) && (infl.size() == 0) && (held.size() == 0);
    endfunction

    task automatic model_reset();
        infl.delete();
        held.delete();
        m_pc    = RESET_PC;
        m_pcif  = RESET_PC;
        m_inst  = 32'h0;
        m_valid = 1'b0;
    endtask

    task automatic model_step();
        bit   granted;
        bit   consume;
        fl_t  f;
        ent_t e;
        granted = m_req() && (imem_gnt === 1'b1);
        consume = m_valid && (stall !== 1'b1);
        if (branch === 1'b1) begin
            m_valid = 1'b0;
            held.delete();
            if (infl.size() > 0) begin
                if (imem_rvalid === 1'b1) f = infl.pop_front();
                else infl[0].dead = 1'b1;
            end else if (granted) begin
                infl.push_back('{pc: m_pc, dead: 1'b1});
            end
            m_pc = {jump_addr[31:2], 2'b00};
        end else begin
            if (infl.size() > 0 && imem_rvalid === 1'b1) begin
                f = infl.pop_front();
                if (f.dead) begin
                    if (consume) m_valid = 1'b0;
                end else if (!m_valid || stall !== 1'b1) begin
                    m_valid = 1'b1;
                    m_pcif  = f.pc;
                    m_inst  = imem_rdata;
                    m_pc    = m_pc + 32'd4;
                end else begin
                    held.push_back('{pc: f.pc, inst: imem_rdata});
                    m_pc = m_pc + 32'd4;
                end
            end else if (held.size() > 0 && consume) begin
                e      = held.pop_front();
                m_pcif = e.pc;
                m_inst = e.inst;
            end else if (consume) begin
                m_valid = 1'b0;
            end
            if (granted) infl.push_back('{pc: m_pc, dead: 1'b0});
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (rst !== 1'b1) model_reset();
            else model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(posedge clk);
            #2;
            chk("inst_valid", 32'(inst_valid), 32'(m_valid));
            chk("PC_IF", PC_IF, m_pcif);
            chk("inst_IF", inst_IF, m_inst);
            chk("imem_req", 32'(imem_req), 32'(m_req()));
            if (m_req()) chk("imem_addr", imem_addr, m_pc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random stimulus ----------------
    initial begin
        int guard;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_pc", PC_IF, RESET_PC);
        chk("rst_inst", inst_IF, 32'h0);
        chk("rst_req", 32'(imem_req), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        // zero-wait memory from reset
        drive_cycle(0, 0, 32'h0, 100, 1, 1);
        drive_cycle(0, 0, 32'h0, 100, 1, 1);
        drive_cycle(0, 0, 32'h0, 100, 1, 1);
        chk("zw_pc0", PC_IF, 32'h0);
        chk("zw_inst0", inst_IF, 32'hA5A5_A5A5);
        chk("zw_valid0", 32'(inst_valid), 32'd1);
        chk("zw_addr4", imem_addr, 32'h4);
        drive_cycle(0, 0, 32'h0, 100, 1, 1);
        chk("zw_gap", 32'(inst_valid), 32'd0);
        drive_cycle(0, 0, 32'h0, 100, 1, 1);
        chk("zw_pc4", PC_IF, 32'h4);
        chk("zw_inst4", inst_IF, 32'hA5A5_A5A1);
        drive_cycle(0, 0, 32'h0, 100, 1, 1);

        // stall 6 cycles while PC=8 is presented
        drive_cycle(1, 0, 32'h0, 100, 1, 1);
        drive_cycle(1, 0, 32'h0, 100, 1, 1);
        drive_cycle(1, 0, 32'h0, 100, 1, 1);
        chk("st_pc8", PC_IF, 32'h8);
        chk("st_inst8", inst_IF, 32'hA5A5_A5AD);
        chk("st_noreq", 32'(imem_req), 32'd0);
        drive_cycle(1, 0, 32'h0, 100, 1, 1);
        drive_cycle(1, 0, 32'h0, 100, 1, 1);
        drive_cycle(1, 0, 32'h0, 100, 1, 1);
        chk("st_hold_pc", PC_IF, 32'h8);
        chk("st_hold_noreq", 32'(imem_req), 32'd0);
        drive_cycle(0, 0, 32'h0, 100, 1, 1);
        drive_cycle(0, 0, 32'h0, 100, 1, 1);
        chk("st_pcC", PC_IF, 32'hC);
        chk("st_instC", inst_IF, 32'hA5A5_A5A9);
        chk("st_req10", 32'(imem_req), 32'd1);
        chk("st_addr10", imem_addr, 32'h10);

        // branch while waiting on a slow response for 0x14
        drive_cycle(0, 0, 32'h0, 100, 1, 1);
        drive_cycle(0, 0, 32'h0, 100, 3, 3);
        drive_cycle(0, 1, 32'h0000_0103, 0, 1, 1);
        drive_cycle(0, 0, 32'h0, 0, 1, 1);
        chk("br_flush", 32'(inst_valid), 32'd0);
        drive_cycle(0, 0, 32'h0, 0, 1, 1);
        drive_cycle(0, 0, 32'h0, 100, 1, 1);
        chk("br_req", 32'(imem_req), 32'd1);
        chk("br_addr", imem_addr, 32'h100);
        drive_cycle(0, 0, 32'h0, 100, 1, 1);
        drive_cycle(1, 0, 32'h0, 100, 1, 1);
        chk("br_pc", PC_IF, 32'h100);
        chk("br_inst", inst_IF, 32'hA5A5_A4A5);

        // branch together with stall while the skid is full
        drive_cycle(1, 0, 32'h0, 100, 1, 1);
        drive_cycle(1, 1, 32'h0000_0200, 100, 1, 1);
        drive_cycle(0, 0, 32'h0, 100, 1, 1);
        chk("bs_valid", 32'(inst_valid), 32'd0);
        chk("bs_addr", imem_addr, 32'h200);
        drive_cycle(0, 0, 32'h0, 100, 1, 1);
        drive_cycle(0, 0, 32'h0, 0, 1, 1);
        chk("bs_pc", PC_IF, 32'h200);
        chk("bs_inst", inst_IF, 32'hA5A5_A7A5);

        // grant withheld; branch redirects the pending request
        drive_cycle(0, 1, 32'h0000_0300, 0, 1, 1);
        chk("ng_req", 32'(imem_req), 32'd1);
        chk("ng_addr_old", imem_addr, 32'h204);
        drive_cycle(0, 0, 32'h0, 0, 1, 1);
        chk("ng_addr_new", imem_addr, 32'h300);
        drive_cycle(0, 0, 32'h0, 0, 1, 1);
        chk("ng_addr_stable", imem_addr, 32'h300);

        // address wrap at the top of the space
        drive_cycle(0, 1, 32'hFFFF_FFFF, 100, 1, 1);
        drive_cycle(0, 0, 32'h0, 100, 1, 1);
        drive_cycle(0, 0, 32'h0, 100, 1, 1);
        chk("wr_addr_top", imem_addr, 32'hFFFF_FFFC);
        drive_cycle(0, 0, 32'h0, 100, 1, 1);
        drive_cycle(0, 0, 32'h0, 0, 1, 1);
        chk("wr_pc_top", PC_IF, 32'hFFFF_FFFC);
        chk("wr_inst_top", inst_IF, 32'h5A5A_5A59);
        chk("wr_addr_zero", imem_addr, 32'h0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive_cycle(int'($urandom_range(99, 0)) < 30,
                        int'($urandom_range(99, 0)) < 5,
                        $urandom, 70, 1, 4);
        end

        // asynchronous reset pulse while a response is outstanding
        guard = 0;
        while (!mem_pend && guard < 50) begin
            drive_cycle(0, 0, 32'h0, 100, 3, 3);
            guard++;
        end
        chk("rp_pending_found", 32'(mem_pend), 32'd1);
        @(posedge clk);
        #2.5;
        rst = 1'b0;
        stall = 1'b0;
        branch = 1'b0;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        #0.5;
        chk("rp_valid", 32'(inst_valid), 32'd0);
        chk("rp_pc", PC_IF, RESET_PC);
        chk("rp_inst", inst_IF, 32'h0);
        chk("rp_req", 32'(imem_req), 32'd0);
        #0.5;
        rst = 1'b1;
        mem_cnt = 0;
        drive_cycle(0, 0, 32'h0, 100, 1, 1);
        chk("rp_req_after", 32'(imem_req), 32'd1);
        chk("rp_addr_after", imem_addr, RESET_PC);
        for (int i = 0; i < 40; i++) begin
            drive_cycle(int'($urandom_range(99, 0)) < 30, 1'b0, 32'h0, 80, 1, 3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
